// File: rtl/cpu_clock.sv
// CPU clock-enable generator: turns qualifying Phi2 (H4) edges into one-clock
// cpu_clken pulses, with an internal divider fallback when Phi2 stops toggling.
module cpu_clock #(
  parameter int SYNC_STAGES  = 2,
  parameter int EDGE_MODE    = 0,
  parameter int TIMEOUT      = 1024,
  parameter int FALLBACK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Phi2,
  output logic        cpu_clken,
  output logic        phi2_lost,
  output logic [15:0] clken_count
);

  // state    | meaning
  // NORMAL   | pulses follow qualifying Phi2 edges
  // FALLBACK | Phi2 silent for TIMEOUT clocks, pulses come from the divider
  typedef enum logic {NORMAL = 1'b0, FALLBACK = 1'b1} state_t;

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(FALLBACK_DIV);

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   qe;
  logic [IW-1:0]          idle, idle_next;
  logic [DW-1:0]          div, div_next;
  logic                   pulse_next;
  logic                   wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Phi2};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    case (EDGE_MODE)
      1:       qe = ~sync[SYNC_STAGES-1] & prev;
      2:       qe = sync[SYNC_STAGES-1] ^ prev;
      default: qe = sync[SYNC_STAGES-1] & ~prev;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NORMAL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL:   if (!qe && idle == IW'(TIMEOUT - 1)) state_next = FALLBACK;
      FALLBACK: if (qe) state_next = NORMAL;
      default:  state_next = NORMAL;
    endcase
  end

  assign wrap = (div == DW'(FALLBACK_DIV - 1));

  always_comb begin
    pulse_next = 1'b0;
    idle_next  = idle;
    div_next   = '0;
    case (state)
      NORMAL: begin
        pulse_next = qe;
        if (qe)                      idle_next = '0;
        else if (idle != IW'(TIMEOUT)) idle_next = idle + 1'b1;
      end
      FALLBACK: begin
        if (qe) begin
          // a divider pulse on the previous clock already stands in for this edge
          pulse_next = ~cpu_clken;
          idle_next  = '0;
        end else begin
          pulse_next = wrap & ~cpu_clken;
          div_next   = wrap ? '0 : div + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_clken   <= 1'b0;
      idle        <= '0;
      div         <= '0;
      clken_count <= '0;
    end else begin
      cpu_clken <= pulse_next;
      idle      <= idle_next;
      div       <= div_next;
      if (cpu_clken) clken_count <= clken_count + 16'd1;
    end
  end

  assign phi2_lost = (state == FALLBACK);

endmodule

// File: tb/tb_cpu_clock.sv
// Scoreboard bench for cpu_clock: three instances (rising, falling, both edges)
// share one Phi2; expected pulse cycles are queued when Phi2 is driven.
module tb_cpu_clock;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Phi2 = 1'b0;
  logic [2:0]  clken;
  logic [2:0]  lost;
  logic [15:0] cnt [3];

  int       cyc = 0;
  int       n_checks = 0;
  int       n_fail = 0;
  int       exp_q [3][$];
  int       n_seen [3];
  int       n_pushed [3];
  logic [2:0] mon_en = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_clock #(.EDGE_MODE(0)) u_rise (.clk(clk), .rst(rst), .Phi2(Phi2),
    .cpu_clken(clken[0]), .phi2_lost(lost[0]), .clken_count(cnt[0]));
  cpu_clock #(.EDGE_MODE(1)) u_fall (.clk(clk), .rst(rst), .Phi2(Phi2),
    .cpu_clken(clken[1]), .phi2_lost(lost[1]), .clken_count(cnt[1]));
  cpu_clock #(.EDGE_MODE(2)) u_both (.clk(clk), .rst(rst), .Phi2(Phi2),
    .cpu_clken(clken[2]), .phi2_lost(lost[2]), .clken_count(cnt[2]));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int i, input int c);
    exp_q[i].push_back(c);
    n_pushed[i]++;
  endtask

  // called right after a falling clock edge; the change is sampled at cycle cyc+1
  task automatic drive(input logic v);
    if (v && !Phi2) begin push_exp(0, cyc + 3); push_exp(2, cyc + 3); end
    if (!v && Phi2) begin push_exp(1, cyc + 3); push_exp(2, cyc + 3); end
    Phi2 = v;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      n_seen[i]   = 0;
      n_pushed[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    Phi2 = 1'b0;
    clear_model();
    rst = 1'b0;
  endtask

  task automatic toggle_periods(input int n);
    repeat (n) begin
      drive(1'b1);
      repeat (4) @(negedge clk);
      drive(1'b0);
      repeat (4) @(negedge clk);
    end
  endtask

  logic due;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (mon_en[i]) begin
          due = (exp_q[i].size() > 0) && (exp_q[i][0] == cyc);
          if (due) void'(exp_q[i].pop_front());
          if (due || clken[i])
            check($sformatf("pulse_u%0d", i), longint'(clken[i]), longint'(due));
          if (clken[i]) begin
            check($sformatf("count_u%0d", i), longint'(cnt[i]), longint'(n_seen[i] % 65536));
            n_seen[i]++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  int c0, p, r, p2, r2, cf;

  initial begin
    clear_model();
    #1 rst = 1'b1;

    // reset held while Phi2 toggles: nothing may come out
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      Phi2 = ((i % 8) < 4);
      check("rst_outputs", longint'({clken, lost, cnt[0], cnt[1], cnt[2]}), 0);
    end
    @(negedge clk);
    Phi2 = 1'b0;
    clear_model();
    rst = 1'b0;
    mon_en = 3'b111;
    repeat (3) @(negedge clk);
    toggle_periods(10);
    repeat (2) @(negedge clk);
    check("cnt_rise", longint'(cnt[0]), n_pushed[0]);
    check("cnt_fall", longint'(cnt[1]), n_pushed[1]);
    check("cnt_both", longint'(cnt[2]), n_pushed[2]);
    check("cnt_rise_abs", longint'(cnt[0]), 10);
    check("cnt_both_abs", longint'(cnt[2]), 20);

    // Phi2 stuck high: timeout, fallback, then recovery
    do_reset();
    mon_en = 3'b001;
    repeat (3) @(negedge clk);
    c0 = cyc;
    drive(1'b1);
    p = c0 + 3;
    r = p + 1024 + 8 * 123 + 4;
    for (int j = 1; p + 1024 + 8 * j < r; j++) push_exp(0, p + 1024 + 8 * j);
    at_cyc(p + 1023);
    check("lost_before_timeout", longint'(lost[0]), 0);
    at_cyc(p + 1024);
    check("lost_at_timeout", longint'(lost[0]), 1);
    at_cyc(r - 7);
    drive(1'b0);
    at_cyc(r - 3);
    drive(1'b1);
    at_cyc(r - 1);
    check("lost_before_recover", longint'(lost[0]), 1);
    at_cyc(r);
    check("lost_recovered", longint'(lost[0]), 0);
    at_cyc(r + 1);
    drive(1'b0);
    repeat (4) @(negedge clk);
    toggle_periods(5);

    // second timeout; the recovering rise lands exactly on a divider wrap
    drive(1'b1);
    p2 = cyc + 3;
    r2 = p2 + 1024 + 16;
    push_exp(0, p2 + 1032);
    at_cyc(p2 + 1024);
    check("lost_timeout2", longint'(lost[0]), 1);
    at_cyc(r2 - 7);
    drive(1'b0);
    at_cyc(r2 - 3);
    drive(1'b1);
    at_cyc(r2 - 1);
    check("lost_before_coinc", longint'(lost[0]), 1);
    at_cyc(r2);
    check("coinc_pulse", longint'(clken[0]), 1);
    check("coinc_lost", longint'(lost[0]), 0);
    at_cyc(r2 + 1);
    check("coinc_single", longint'(clken[0]), 0);
    check("coinc_count", longint'(cnt[0]), n_pushed[0]);
    repeat (4) @(negedge clk);

    // asynchronous reset while the pulse is high
    do_reset();
    mon_en = 3'b001;
    repeat (3) @(negedge clk);
    toggle_periods(3);
    c0 = cyc;
    drive(1'b1);
    at_cyc(c0 + 3);
    check("pre_rst_clken", longint'(clken[0]), 1);
    check("pre_rst_count", longint'(cnt[0]), 3);
    rst = 1'b1;
    #1;
    check("async_rst_clken", longint'(clken[0]), 0);
    check("async_rst_count", longint'(cnt[0]), 0);
    check("async_rst_lost", longint'(lost[0]), 0);

    // clken_count wrap: both-edge instance pulses every clock
    @(negedge clk);
    mon_en = 3'b000;
    Phi2 = 1'b0;
    clear_model();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cf = cyc;
    for (int i = 0; i < 65545; i++) begin
      Phi2 = ~Phi2;
      if (cyc == cf + 3 + 65535) begin
        check("wrap_ffff", longint'(cnt[2]), 65535);
        check("wrap_clken", longint'(clken[2]), 1);
      end
      if (cyc == cf + 3 + 65536) check("wrap_0000", longint'(cnt[2]), 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
